imem_write_arbiter: RTL and testbench

//  Shares the single IMEM write port (port A: ena/wea/addra/dina) between two requesters.

---
 rtl/imem_arb_pkg.sv | 21 ++
 rtl/imem_write_arbiter_if.sv | 46 ++++
 rtl/imem_arb_aging_ctr.sv | 27 ++
 rtl/imem_write_arbiter.sv | 122 ++++++++++++
 tb/tb_imem_write_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the IMEM port-A write arbiter.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_DRAIN = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  typedef enum logic {
    SRC_CPU = 1'b0,
    SRC_LDR = 1'b1
  } src_t;

  localparam int unsigned STATS_W = 16;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == '1) ? v : v + STATS_W'(1);
  endfunction

endpackage

// File: rtl/imem_write_arbiter_if.sv
// Request, IMEM port-A and status bundle between the two requesters and the arbiter.
interface imem_write_arbiter_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned MASK_W  = DATA_W / 8;
  localparam int unsigned STATS_W = imem_arb_pkg::STATS_W;

  logic                boot_mode;
  logic                cpu_valid;
  logic                cpu_ready;
  logic [ADDR_W-1:0]   cpu_addr;
  logic [DATA_W-1:0]   cpu_data;
  logic [MASK_W-1:0]   cpu_wmask;
  logic                ldr_valid;
  logic                ldr_ready;
  logic [ADDR_W-1:0]   ldr_addr;
  logic [DATA_W-1:0]   ldr_data;
  logic [MASK_W-1:0]   ldr_wmask;
  logic                imem_ena;
  logic [MASK_W-1:0]   imem_wea;
  logic [ADDR_W-1:0]   imem_addra;
  logic [DATA_W-1:0]   imem_dina;
  logic                busy;
  logic [STATS_W-1:0]  cpu_wr_cnt;
  logic [STATS_W-1:0]  ldr_wr_cnt;

  modport master (
    output boot_mode,
    output cpu_valid, cpu_addr, cpu_data, cpu_wmask,
    output ldr_valid, ldr_addr, ldr_data, ldr_wmask,
    input  cpu_ready, ldr_ready,
    input  imem_ena, imem_wea, imem_addra, imem_dina,
    input  busy, cpu_wr_cnt, ldr_wr_cnt
  );

  modport slave (
    input  boot_mode,
    input  cpu_valid, cpu_addr, cpu_data, cpu_wmask,
    input  ldr_valid, ldr_addr, ldr_data, ldr_wmask,
    output cpu_ready, ldr_ready,
    output imem_ena, imem_wea, imem_addra, imem_dina,
    output busy, cpu_wr_cnt, ldr_wr_cnt
  );

endinterface

// File: rtl/imem_arb_aging_ctr.sv
// Saturating count of contended loader wait cycles; sat lets the loader pre-empt the CPU.
module imem_arb_aging_ctr #(
  parameter int unsigned MAX_STALL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int unsigned CNT_W = $clog2(MAX_STALL + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != CNT_W'(MAX_STALL))) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign sat = (r_cnt == CNT_W'(MAX_STALL));

endmodule

// File: rtl/imem_write_arbiter.sv
// Arbitrates CPU stores and the UART boot loader onto IMEM port A through a registered stage.
// Optional write statistics: define IMEM_ARB_STATS_EN.
module imem_write_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_STALL = 4
) (
  input logic clk,
  input logic rst,
  imem_write_arbiter_if.slave bus
);
  localparam int unsigned MASK_W = DATA_W / 8;

  state_t            r_state;
  logic              r_ena;
  logic [MASK_W-1:0] r_wea;
  logic [ADDR_W-1:0] r_addra;
  logic [DATA_W-1:0] r_dina;

  logic              w_sat;
  logic              w_cpu_ready;
  logic              w_ldr_ready;
  logic              w_cpu_xfer;
  logic              w_ldr_xfer;
  logic              w_issue;
  src_t              w_src;
  logic [MASK_W-1:0] w_mask;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  always_comb begin
    w_cpu_ready = 1'b0;
    w_ldr_ready = 1'b0;
    case (r_state)
      S_BOOT: w_ldr_ready = bus.ldr_valid;
      S_RUN: begin
        if (w_sat) begin
          w_ldr_ready = bus.ldr_valid;
        end else if (bus.cpu_valid) begin
          w_cpu_ready = 1'b1;
        end else begin
          w_ldr_ready = bus.ldr_valid;
        end
      end
      default: ;
    endcase
  end

  assign w_cpu_xfer = bus.cpu_valid & w_cpu_ready;
  assign w_ldr_xfer = bus.ldr_valid & w_ldr_ready;
  assign w_src      = w_ldr_xfer ? SRC_LDR : SRC_CPU;
  assign w_mask     = (w_src == SRC_LDR) ? bus.ldr_wmask : bus.cpu_wmask;
  assign w_addr     = (w_src == SRC_LDR) ? bus.ldr_addr  : bus.cpu_addr;
  assign w_data     = (w_src == SRC_LDR) ? bus.ldr_data  : bus.cpu_data;
  // An all-zero mask still completes the handshake but never reaches IMEM.
  assign w_issue    = (w_cpu_xfer | w_ldr_xfer) & (|w_mask);

  imem_arb_aging_ctr #(
    .MAX_STALL (MAX_STALL)
  ) u_aging (
    .clk (clk),
    .rst (rst),
    .inc ((r_state == S_RUN) & bus.ldr_valid & ~w_ldr_ready),
    .clr (w_ldr_xfer | ~bus.ldr_valid),
    .sat (w_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_BOOT;
      r_ena   <= 1'b0;
      r_wea   <= '0;
      r_addra <= '0;
      r_dina  <= '0;
    end else begin
      r_ena <= w_issue;
      r_wea <= w_issue ? w_mask : '0;
      if (w_issue) begin
        r_addra <= w_addr;
        r_dina  <= w_data;
      end
      case (r_state)
        S_BOOT:  if (!bus.boot_mode) r_state <= S_DRAIN;
        S_DRAIN: r_state <= S_RUN;
        S_RUN:   if (bus.boot_mode) r_state <= S_BOOT;
        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign bus.cpu_ready  = w_cpu_ready;
  assign bus.ldr_ready  = w_ldr_ready;
  assign bus.imem_ena   = r_ena;
  assign bus.imem_wea   = r_wea;
  assign bus.imem_addra = r_addra;
  assign bus.imem_dina  = r_dina;
  assign bus.busy       = (r_state == S_DRAIN) | r_ena;

`ifdef IMEM_ARB_STATS_EN
  logic [STATS_W-1:0] r_cpu_cnt;
  logic [STATS_W-1:0] r_ldr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_cnt <= '0;
      r_ldr_cnt <= '0;
    end else if (w_issue) begin
      if (w_src == SRC_CPU) r_cpu_cnt <= sat_inc(r_cpu_cnt);
      else                  r_ldr_cnt <= sat_inc(r_ldr_cnt);
    end
  end

  assign bus.cpu_wr_cnt = r_cpu_cnt;
  assign bus.ldr_wr_cnt = r_ldr_cnt;
`else
  assign bus.cpu_wr_cnt = '0;
  assign bus.ldr_wr_cnt = '0;
`endif

endmodule

// File: tb/tb_imem_write_arbiter.sv
// Randomized scoreboard bench for imem_write_arbiter against a behavioural arbitration model.
module tb_imem_write_arbiter;
  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;
  localparam int MAXS = 4;
  localparam int MODE_BOOT = 0, MODE_DRAIN = 1, MODE_RUN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  imem_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STALL(MAXS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          cr;
    bit          lr;
    bit          ena;
    bit          busy;
    logic [3:0]  wea;
    logic [13:0] addr;
    logic [31:0] data;
    int          ccnt;
    int          lcnt;
  } cyc_t;

  typedef struct {
    logic [13:0] addr;
    logic [31:0] data;
    logic [3:0]  wea;
  } wr_t;

  cyc_t cyc_q[$];
  wr_t  wr_q[$];
  int   nchk = 0;
  int   nerr = 0;

  // reference model state
  int          m_mode = MODE_BOOT;
  int          m_stall = 0;
  bit          m_ena = 1'b0;
  logic [3:0]  m_wea = '0;
  logic [13:0] m_addr = '0;
  logic [31:0] m_data = '0;
  int          m_ccnt = 0;
  int          m_lcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rs, input bit bm,
                      input bit cv, input logic [13:0] ca, input logic [31:0] cd, input logic [3:0] cm,
                      input bit lv, input logic [13:0] la, input logic [31:0] ld, input logic [3:0] lm);
    bit cr, lr, cx, lx;
    cyc_t c;
    wr_t w;
    logic [3:0] msk;
    @(posedge clk);
    #1;
    rst = rs;
    bus.boot_mode = bm;
    bus.cpu_valid = cv; bus.cpu_addr = ca; bus.cpu_data = cd; bus.cpu_wmask = cm;
    bus.ldr_valid = lv; bus.ldr_addr = la; bus.ldr_data = ld; bus.ldr_wmask = lm;

    cr = 1'b0;
    lr = 1'b0;
    if (m_mode == MODE_BOOT) lr = lv;
    else if (m_mode == MODE_RUN) begin
      if (m_stall == MAXS) lr = lv;
      else if (cv) cr = 1'b1;
      else lr = lv;
    end

    c.cr = cr; c.lr = lr; c.ena = m_ena; c.busy = (m_mode == MODE_DRAIN) || m_ena;
    c.wea = m_wea; c.addr = m_addr; c.data = m_data;
`ifdef IMEM_ARB_STATS_EN
    c.ccnt = m_ccnt; c.lcnt = m_lcnt;
`else
    c.ccnt = 0; c.lcnt = 0;
`endif
    cyc_q.push_back(c);

    if (rs) begin
      m_mode = MODE_BOOT; m_stall = 0; m_ena = 1'b0; m_wea = '0;
      m_addr = '0; m_data = '0; m_ccnt = 0; m_lcnt = 0;
    end else begin
      cx = cv && cr;
      lx = lv && lr;
      m_ena = 1'b0;
      m_wea = '0;
      if (cx || lx) begin
        msk = cx ? cm : lm;
        if (msk != 4'h0) begin
          m_ena = 1'b1; m_wea = msk;
          m_addr = cx ? ca : la;
          m_data = cx ? cd : ld;
          w.addr = m_addr; w.data = m_data; w.wea = msk;
          wr_q.push_back(w);
          if (cx) m_ccnt = (m_ccnt < 65535) ? m_ccnt + 1 : m_ccnt;
          else    m_lcnt = (m_lcnt < 65535) ? m_lcnt + 1 : m_lcnt;
        end
      end
      if (lx || !lv) m_stall = 0;
      else if (m_mode == MODE_RUN) m_stall = (m_stall < MAXS) ? m_stall + 1 : MAXS;
      case (m_mode)
        MODE_BOOT:  if (!bm) m_mode = MODE_DRAIN;
        MODE_DRAIN: m_mode = MODE_RUN;
        default:    if (bm) m_mode = MODE_BOOT;
      endcase
    end
  endtask

  task automatic idle(input bit bm);
    step(1'b0, bm, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  // monitor: per-cycle expectations plus an in-order write scoreboard popped on imem_ena
  always @(negedge clk) begin
    cyc_t c;
    wr_t  w;
    if (cyc_q.size() > 0) begin
      c = cyc_q.pop_front();
      chk("cpu_ready", 32'(bus.cpu_ready), 32'(c.cr));
      chk("ldr_ready", 32'(bus.ldr_ready), 32'(c.lr));
      chk("imem_ena", 32'(bus.imem_ena), 32'(c.ena));
      chk("imem_wea", 32'(bus.imem_wea), 32'(c.wea));
      chk("imem_addra", 32'(bus.imem_addra), 32'(c.addr));
      chk("imem_dina", bus.imem_dina, c.data);
      chk("busy", 32'(bus.busy), 32'(c.busy));
      chk("cpu_wr_cnt", 32'(bus.cpu_wr_cnt), 32'(c.ccnt));
      chk("ldr_wr_cnt", 32'(bus.ldr_wr_cnt), 32'(c.lcnt));
      if (bus.imem_ena === 1'b1) begin
        if (wr_q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_write: got addr %0h expected no write", bus.imem_addra);
        end else begin
          w = wr_q.pop_front();
          chk("wr_addr", 32'(bus.imem_addra), 32'(w.addr));
          chk("wr_data", bus.imem_dina, w.data);
          chk("wr_wea", 32'(bus.imem_wea), 32'(w.wea));
        end
      end
    end
  end

  initial begin
    logic [13:0] a1, a2;
    logic [31:0] d1, d2;
    logic [3:0]  k1, k2;
    bit bm, r, cv, lv;
    bus.boot_mode = 1'b1;
    bus.cpu_valid = 1'b0; bus.cpu_addr = '0; bus.cpu_data = '0; bus.cpu_wmask = '0;
    bus.ldr_valid = 1'b0; bus.ldr_addr = '0; bus.ldr_data = '0; bus.ldr_wmask = '0;
    repeat (2) @(posedge clk);

    // boot: loader wins even with CPU pending
    step(1'b0, 1'b1, 1'b1, 14'h0100, 32'h11111111, 4'hF, 1'b1, 14'h0010, 32'hDEADBEEF, 4'hF);
    idle(1'b1);
    // leave boot: one drain cycle, then a narrow CPU write at the top address
    idle(1'b0);
    step(1'b0, 1'b0, 1'b1, 14'h3FFF, 32'hCAFEF00D, 4'b0011, 1'b1, 14'h0001, 32'h1, 4'hF);
    step(1'b0, 1'b0, 1'b1, 14'h3FFF, 32'hCAFEF00D, 4'b0011, 1'b0, '0, '0, '0);
    idle(1'b0);
    // sustained contention: 4:1 aging pattern
    for (int i = 0; i < 15; i++)
      step(1'b0, 1'b0, 1'b1, 14'(i), $urandom, 4'hF, 1'b1, 14'(16'h2000 + i), $urandom, 4'hF);
    idle(1'b0);
    // loader write with empty mask is accepted but dropped
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 14'h0123, 32'h55AA55AA, 4'h0);
    idle(1'b0);
    // reset on a cycle with an accepted CPU write
    step(1'b0, 1'b0, 1'b1, 14'h0777, 32'h01234567, 4'hF, 1'b0, '0, '0, '0);
    step(1'b1, 1'b0, 1'b1, 14'h0778, 32'h89ABCDEF, 4'hF, 1'b0, '0, '0, '0);
    step(1'b0, 1'b1, 1'b1, 14'h0779, 32'h0, 4'hF, 1'b0, '0, '0, '0);
    // statistics: 2 loader writes in boot, 3 CPU writes in run
    step(1'b0, 1'b1, 1'b0, '0, '0, '0, 1'b1, 14'h0004, 32'hA0, 4'hF);
    step(1'b0, 1'b1, 1'b0, '0, '0, '0, 1'b1, 14'h0005, 32'hA1, 4'h1);
    idle(1'b0);
    idle(1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b1, 14'(i + 8), 32'(i), 4'hC, 1'b0, '0, '0, '0);
    idle(1'b0);
    idle(1'b0);

    // randomized traffic with occasional mode switches and resets
    bm = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) bm = ~bm;
      r  = ($urandom_range(0, 199) == 0);
      cv = ($urandom_range(0, 3) != 0);
      lv = ($urandom_range(0, 3) != 0);
      a1 = 14'($urandom); a2 = 14'($urandom);
      d1 = $urandom;      d2 = $urandom;
      k1 = 4'($urandom);  k2 = 4'($urandom);
      step(r, bm, cv, a1, d1, k1, lv, a2, d2, k2);
    end
    idle(1'b0);
    idle(1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("pending_writes", 32'(wr_q.size()), 32'd0);
    chk("pending_cycles", 32'(cyc_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
